dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of the single-port 16-bit data memory.
//  Port 0 is the CPU load/store path; port 1 is the loader/debug path.
//  Latches one request, drives the memory read/write strobes for exactly one cycle, waits out the read latency, then acks the winner.
//  Out-of-range addresses are rejected without touching memory.
// PARAMETERS
//  DATA_W     16   data width of both ports and the memory
//  ADDR_W     16   address width of both ports and the memory
//  MEM_DEPTH  100  valid words; an address >= MEM_DEPTH is out of range
//  READ_LAT   1    cycles from the mem_read strobe to valid mem_rdata (1..7)
//  RR_EN      1    1 = round-robin between ports; 0 = fixed priority to port 0
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous active-high reset
//  req0       in   1       port 0 request; held high until ack0
//  we0        in   1       port 0: 1 = write, 0 = read
//  addr0      in   ADDR_W  port 0 word address
//  wdata0     in   DATA_W  port 0 write data
//  ack0       out  1       port 0 done; one-cycle pulse
//  rdata0     out  DATA_W  port 0 read data; valid while ack0 is high
//  req1/we1/addr1/wdata1/ack1/rdata1   same as port 0, for port 1
//  err        out  1       pulses with ack when the address was out of range
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_write  out  1       memory write strobe
//  mem_read   out  1       memory read strobe
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; last_grant=1 so port 0 wins the first tie.
//    ack0, ack1, err, mem_write, mem_read and busy reset to 0.
//    rdata0, rdata1, mem_addr and mem_wdata reset to 0. All outputs are registered.
//  - FSM states: IDLE, ISSUE, WAIT, DONE.
//  - IDLE: if any req is high, pick a winner.
//    RR_EN=1: if both are high, grant the port != last_grant. RR_EN=0: port 0 wins.
//    Latch the winner's we, addr and wdata; set last_grant; go to ISSUE.
//  - ISSUE: one cycle. In range: mem_write=we, mem_read=~we, mem_addr and mem_wdata = latched values.
//    Write -> DONE. Read with READ_LAT=1 -> DONE. Read with READ_LAT>1 -> WAIT, cnt=READ_LAT-1.
//    Out of range: no strobe; err_q=1; -> DONE.
//  - WAIT: strobes low; cnt decrements; at cnt==1 -> DONE.
//  - DONE: one cycle. ackN=1 for the granted port only; err=err_q.
//    rdataN = mem_rdata on an in-range read, 0 on a write or an out-of-range access.
//    The other port's rdata holds its value. Next state is IDLE.
//  - Latency with both ports idle: req->ack = 3 cycles for writes, 2+READ_LAT cycles for reads.
//    Minimum spacing between acks is 3 cycles.
//  - Strobes: mem_read and mem_write are high for exactly one cycle per transaction and never together.
//  - A req dropping mid-transaction has no effect: the transaction completes and ack still pulses.
//  - A req still high in the cycle after its ack is a new request; the requester must drop it in the ack cycle.
//  - Addr/data changes while busy are ignored; the latched copies are used.
//  - Reset mid-transaction aborts it: no ack, and any strobe drops asynchronously.
//  - Address check is unsigned: addr >= MEM_DEPTH is out of range (e.g. 100, 0xFFFF).
// TESTING
//  1 Port 0 write addr=5 data=0xBEEF, then read addr=5 ->
//    mem_write 1 cycle, ack0 at cycle 3; read ack0 at cycle 3 (READ_LAT=1) with rdata0=0xBEEF, err=0.
//  2 req0 and req1 high together, back-to-back, RR_EN=1 ->
//    grants alternate 0,1,0,1 starting with port 0; RR_EN=0 -> port 0 wins every tie.
//  3 Port 1 read addr=100, then addr=0xFFFF ->
//    no mem strobes, ack1 with err=1 and rdata1=0; addr=99 -> normal access, err=0.
//  4 READ_LAT=3, port 0 read ->
//    mem_read 1 cycle, ack0 exactly 5 cycles after req0, rdata0 = mem_rdata sampled in DONE.
//  5 rst pulse during WAIT ->
//    state IDLE, no ack, all outputs 0; the next req0 is serviced normally with port 0 priority.
//  6 req1 dropped one cycle after its grant ->
//    the transaction still completes with ack1; no extra transaction follows.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of a single-port data memory.
// Latches one request, strobes the memory for one cycle, waits out the read latency, then acks the winner.
module dmem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 100,
    parameter int READ_LAT  = 1,
    parameter int RR_EN     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [2:0]      CNT_INIT = 3'(READ_LAT - 1);
    localparam logic            LAT1     = (READ_LAT <= 1);

    state_t            state_q;
    logic              last_grant_q, grant_q, we_q, err_q;
    logic [2:0]        cnt_q;
    logic              ack0_q, ack1_q, err_o_q, mem_write_q, mem_read_q, busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, rdata0_q, rdata1_q;

    logic              grant_d, win_we_d, win_in_range_d, fin_d;
    logic [ADDR_W-1:0] win_addr_d;
    logic [DATA_W-1:0] win_wdata_d, done_rdata_d;

    // Winner selection, range check and completion decode
    always_comb begin
        grant_d = 1'b0;
        if (req0 && req1) begin
            if (RR_EN != 0) grant_d = ~last_grant_q;
            else            grant_d = 1'b0;
        end else if (req1) begin
            grant_d = 1'b1;
        end else begin
            grant_d = 1'b0;
        end

        if (grant_d) begin
            win_we_d    = we1;
            win_addr_d  = addr1;
            win_wdata_d = wdata1;
        end else begin
            win_we_d    = we0;
            win_addr_d  = addr0;
            win_wdata_d = wdata0;
        end
        win_in_range_d = ({1'b0, win_addr_d} < DEPTH_L);

        fin_d = 1'b0;
        if (state_q == ISSUE)     fin_d = err_q | we_q | LAT1;
        else if (state_q == WAIT) fin_d = (cnt_q == 3'd1);
        else                      fin_d = 1'b0;

        if (err_q || we_q) done_rdata_d = '0;
        else               done_rdata_d = mem_rdata;
    end

    // Sequencer FSM with registered outputs; strobes are set on entry to ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 3'd0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err_o_q      <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            busy_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_o_q     <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= win_we_d;
                        err_q        <= ~win_in_range_d;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                        // Out-of-range accesses never reach the memory pins
                        if (win_in_range_d) begin
                            mem_write_q <= win_we_d;
                            mem_read_q  <= ~win_we_d;
                            mem_addr_q  <= win_addr_d;
                            mem_wdata_q <= win_wdata_d;
                        end
                    end
                end
                ISSUE: begin
                    if (fin_d) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (fin_d) state_q <= DONE;
                    else       cnt_q   <= cnt_q - 3'd1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (fin_d) begin
                ack0_q  <= ~grant_q;
                ack1_q  <= grant_q;
                err_o_q <= err_q;
                if (grant_q) rdata1_q <= done_rdata_d;
                else         rdata0_q <= done_rdata_d;
            end
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign err       = err_o_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: instance 0 is round-robin with READ_LAT=1, instance 1 is fixed priority with READ_LAT=3.
module tb_dmem_arbiter;

    typedef struct {
        int          port;
        logic        err;
        logic [15:0] rdata;
        int          lat;
        int          strobes;
        int          start;
    } exp_t;

    logic        clk;
    logic [1:0]  rst_s;
    logic [1:0]  req_s [2];
    logic [1:0]  we_s [2];
    logic [15:0] addr_s [2][2];
    logic [15:0] wdata_s [2][2];
    logic        ack0_s [2];
    logic        ack1_s [2];
    logic        err_s [2];
    logic        mem_write_s [2];
    logic        mem_read_s [2];
    logic        busy_s [2];
    logic [15:0] rdata0_s [2];
    logic [15:0] rdata1_s [2];
    logic [15:0] mem_addr_s [2];
    logic [15:0] mem_wdata_s [2];
    logic [15:0] mem_rdata_s [2];

    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          strobes [2];
    logic [15:0] last_rd [2][2];
    int          tmo = 0;
    int          tmo_seen = 0;
    logic        drain_req = 1'b0;
    logic        drain_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0] mem [0:127];
        logic [7:0]  hist;
        logic        rd_valid;

        dmem_arbiter #(
            .DATA_W(16), .ADDR_W(16), .MEM_DEPTH(100), .READ_LAT(LAT), .RR_EN((g == 0) ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst_s[g]),
            .req0(req_s[g][0]), .we0(we_s[g][0]), .addr0(addr_s[g][0]), .wdata0(wdata_s[g][0]),
            .ack0(ack0_s[g]), .rdata0(rdata0_s[g]),
            .req1(req_s[g][1]), .we1(we_s[g][1]), .addr1(addr_s[g][1]), .wdata1(wdata_s[g][1]),
            .ack1(ack1_s[g]), .rdata1(rdata1_s[g]),
            .err(err_s[g]), .mem_addr(mem_addr_s[g]), .mem_wdata(mem_wdata_s[g]),
            .mem_write(mem_write_s[g]), .mem_read(mem_read_s[g]), .mem_rdata(mem_rdata_s[g]),
            .busy(busy_s[g])
        );

        // Memory model: read data is only valid in the LAT-th cycle counting the strobe cycle as the first
        always @(posedge clk) begin
            hist <= {hist[6:0], mem_read_s[g]};
            if (mem_write_s[g]) mem[mem_addr_s[g][6:0]] <= mem_wdata_s[g];
        end
        if (LAT == 1) begin : g_l1
            assign rd_valid = mem_read_s[g];
        end else begin : g_ln
            assign rd_valid = hist[LAT-2];
        end
        assign mem_rdata_s[g] = rd_valid ? mem[mem_addr_s[g][6:0]] : 16'hDEAD;
    end

    // Monitor: checks reset values, strobe rules and every ack against the scoreboard
    always @(negedge clk) begin
        exp_t        e;
        logic        have;
        logic        ack_ok;
        int          lat;
        logic [15:0] rd;
        logic [15:0] ord;
        for (int g = 0; g < 2; g++) begin
            if (rst_s[g]) begin
                n_chk++;
                if ({ack0_s[g], ack1_s[g], err_s[g], mem_write_s[g], mem_read_s[g], busy_s[g],
                     rdata0_s[g], rdata1_s[g], mem_addr_s[g], mem_wdata_s[g]} != 70'd0) begin
                    n_fail++;
                    $display("FAIL reset_outputs inst%0d: got ack=%b%b err=%b wr=%b rd=%b busy=%b rdata=%h/%h maddr=%h mwdata=%h, required all zero",
                             g, ack0_s[g], ack1_s[g], err_s[g], mem_write_s[g], mem_read_s[g], busy_s[g],
                             rdata0_s[g], rdata1_s[g], mem_addr_s[g], mem_wdata_s[g]);
                end
                strobes[g]    = 0;
                last_rd[g][0] = 16'h0000;
                last_rd[g][1] = 16'h0000;
            end else begin
                if (mem_read_s[g] || mem_write_s[g]) begin
                    strobes[g]++;
                    n_chk++;
                    if (mem_read_s[g] && mem_write_s[g]) begin
                        n_fail++;
                        $display("FAIL strobe_overlap inst%0d: got read=1 write=1, required at most one", g);
                    end
                end
                if (err_s[g] && !ack0_s[g] && !ack1_s[g]) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL err_without_ack inst%0d: got err=1 with no ack, required err=0", g);
                end
                if (ack0_s[g] || ack1_s[g]) begin
                    n_chk++;
                    have = 1'b0;
                    if (g == 0 && exp_q0.size() > 0) begin
                        e = exp_q0.pop_front();
                        have = 1'b1;
                    end else if (g == 1 && exp_q1.size() > 0) begin
                        e = exp_q1.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        n_fail++;
                        $display("FAIL unexpected_ack inst%0d: got ack0=%b ack1=%b, required no ack", g, ack0_s[g], ack1_s[g]);
                    end else begin
                        ack_ok = (e.port == 0) ? (ack0_s[g] && !ack1_s[g]) : (ack1_s[g] && !ack0_s[g]);
                        rd     = (e.port == 0) ? rdata0_s[g] : rdata1_s[g];
                        ord    = (e.port == 0) ? rdata1_s[g] : rdata0_s[g];
                        lat    = cyc - e.start + 1;
                        if (!ack_ok || err_s[g] !== e.err || rd !== e.rdata || ord !== last_rd[g][1-e.port] ||
                            (e.lat != 0 && lat != e.lat) || strobes[g] != e.strobes) begin
                            n_fail++;
                            $display("FAIL ack inst%0d: got ack=%b%b err=%b rdata=%h other=%h lat=%0d strobes=%0d, required port%0d err=%b rdata=%h other=%h lat=%0d strobes=%0d",
                                     g, ack1_s[g], ack0_s[g], err_s[g], rd, ord, lat, strobes[g],
                                     e.port, e.err, e.rdata, last_rd[g][1-e.port], e.lat, e.strobes);
                        end
                        last_rd[g][e.port] = e.rdata;
                    end
                    strobes[g] = 0;
                end
            end
        end
        if (tmo != tmo_seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: got %0d expired waits, required 0", tmo - tmo_seen);
            tmo_seen = tmo;
        end
        if (drain_req && !drain_done) begin
            n_chk++;
            if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d/%0d outstanding, required 0/0", exp_q0.size(), exp_q1.size());
            end
            drain_done = 1'b1;
        end
        cyc++;
    end

    task automatic push_exp(input int g, input int p, input logic er, input logic [15:0] rd,
                            input int lat, input int st);
        exp_t e;
        e.port = p; e.err = er; e.rdata = rd; e.lat = lat; e.strobes = st; e.start = cyc;
        if (g == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // One transaction; latched fields are scrambled after the grant to prove they are ignored
    task automatic do_req(input int g, input int p, input logic we, input logic [15:0] a,
                          input logic [15:0] d, input int lat, input logic er,
                          input logic [15:0] rd, input logic drop_early);
        int   n;
        logic got;
        @(posedge clk);
        #1;
        push_exp(g, p, er, rd, lat, er ? 0 : 1);
        req_s[g][p] = 1'b1; we_s[g][p] = we; addr_s[g][p] = a; wdata_s[g][p] = d;
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                addr_s[g][p]  = ~a;
                wdata_s[g][p] = ~d;
                we_s[g][p]    = ~we;
                if (drop_early) req_s[g][p] = 1'b0;
            end
            got = (p == 0) ? ack0_s[g] : ack1_s[g];
        end
        req_s[g][p] = 1'b0;
        if (!got) tmo++;
    endtask

    // Both ports contend with writes; each port re-requests in the cycle after its ack
    task automatic tie_run(input int g, input int n0, input int n1);
        int         left [2];
        int         guard;
        logic [1:0] raise;
        left[0] = n0;
        left[1] = n1;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            we_s[g][p] = 1'b1;
            addr_s[g][p] = 16'(10 + p);
            wdata_s[g][p] = 16'hA000 + 16'(p);
        end
        req_s[g] = {(n1 > 0), (n0 > 0)};
        guard = 0;
        while ((left[0] + left[1]) > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
            raise = 2'b00;
            if (ack0_s[g] && req_s[g][0]) begin
                left[0]--; req_s[g][0] = 1'b0; raise[0] = (left[0] > 0);
            end
            if (ack1_s[g] && req_s[g][1]) begin
                left[1]--; req_s[g][1] = 1'b0; raise[1] = (left[1] > 0);
            end
            if (raise != 2'b00) begin
                @(posedge clk);
                #1;
                req_s[g] = req_s[g] | raise;
            end
        end
        req_s[g] = 2'b00;
        if (guard >= 100) tmo++;
    endtask

    initial begin
        rst_s = 2'b11;
        for (int g = 0; g < 2; g++) begin
            req_s[g] = 2'b00;
            we_s[g]  = 2'b00;
            for (int p = 0; p < 2; p++) begin
                addr_s[g][p]  = 16'h0000;
                wdata_s[g][p] = 16'h0000;
            end
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_s = 2'b00;

        // Ties: round-robin alternates starting at port 0; fixed priority favours port 0
        for (int i = 0; i < 4; i++) push_exp(0, i % 2, 1'b0, 16'h0000, 0, 1);
        tie_run(0, 2, 2);
        push_exp(1, 0, 1'b0, 16'h0000, 0, 1);
        push_exp(1, 0, 1'b0, 16'h0000, 0, 1);
        push_exp(1, 0, 1'b0, 16'h0000, 0, 1);
        push_exp(1, 1, 1'b0, 16'h0000, 0, 1);
        tie_run(1, 3, 1);

        // Write then read back on port 0
        do_req(0, 0, 1'b1, 16'd5, 16'hBEEF, 3, 1'b0, 16'h0000, 1'b0);
        do_req(0, 0, 1'b0, 16'd5, 16'h0000, 3, 1'b0, 16'hBEEF, 1'b0);

        // Range boundary on port 1
        do_req(0, 1, 1'b0, 16'd100,  16'h0000, 3, 1'b1, 16'h0000, 1'b0);
        do_req(0, 1, 1'b0, 16'hFFFF, 16'h0000, 3, 1'b1, 16'h0000, 1'b0);
        do_req(0, 1, 1'b1, 16'd99,   16'h0099, 3, 1'b0, 16'h0000, 1'b0);
        do_req(0, 1, 1'b0, 16'd99,   16'h0000, 3, 1'b0, 16'h0099, 1'b0);

        // Requester drops early: still completes, nothing follows
        do_req(0, 1, 1'b0, 16'd5, 16'h0000, 3, 1'b0, 16'hBEEF, 1'b1);
        repeat (6) @(negedge clk);

        // Longer read latency
        do_req(1, 0, 1'b1, 16'd7, 16'h1234, 3, 1'b0, 16'h0000, 1'b0);
        do_req(1, 0, 1'b0, 16'd7, 16'h0000, 5, 1'b0, 16'h1234, 1'b0);

        // Reset while waiting for read data aborts the transaction
        @(posedge clk);
        #1;
        req_s[1][0] = 1'b1; we_s[1][0] = 1'b0; addr_s[1][0] = 16'd7;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_s[1] = 1'b1;
        req_s[1][0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_s[1] = 1'b0;
        repeat (6) @(negedge clk);
        push_exp(1, 0, 1'b0, 16'h0000, 0, 1);
        push_exp(1, 1, 1'b0, 16'h0000, 0, 1);
        tie_run(1, 1, 1);

        repeat (4) @(negedge clk);
        drain_req = 1'b1;
        for (int k = 0; k < 10 && !drain_done; k++) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
